beam_scan_ctrl: RTL and testbench

//  Drives the combinational 4-element |sum(x*s)|^2 power block: latches one snapshot of 4 complex

---
 rtl/beam_scan_pkg.sv | 52 +++++
 rtl/beam_scan_ctrl_steer_lut.sv | 43 ++++
 rtl/beam_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_beam_scan_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_scan_pkg.sv
// Shared types, default widths and the built-in steering table
// used by the DoA beam-scan controller.
package beam_scan_pkg;

  localparam int N_ELEM          = 4;
  localparam int DEF_WORD_LENGTH = 12;
  localparam int DEF_Y_WL        = DEF_WORD_LENGTH*2+3;
  localparam int DEF_PWR_W       = 2*DEF_Y_WL;
  localparam int DEF_N_ANGLES    = 64;
  localparam int DEF_ANGLE_W     = $clog2(DEF_N_ANGLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // 16-point cosine, amplitude 2000 (fits a 12-bit signed word)
  function automatic int cos16(input int p);
    int v;
    unique case (p & 15)
      0:       v = 2000;
      1, 15:   v = 1848;
      2, 14:   v = 1414;
      3, 13:   v = 765;
      4, 12:   v = 0;
      5, 11:   v = -765;
      6, 10:   v = -1414;
      7, 9:    v = -1848;
      default: v = -2000;
    endcase
    return v;
  endfunction

  function automatic int sin16(input int p);
    return cos16(p + 12);
  endfunction

  // Element 1 is the phase reference, so no two angles differ
  // only by a common rotation.
  function automatic int steer_phase(input int idx, input int e);
    int p;
    unique case (e)
      0:       p = 0;
      1:       p = idx;
      2:       p = 2*idx + 5*(idx/16);
      default: p = 3*idx;
    endcase
    return p & 15;
  endfunction

endpackage

// File: rtl/beam_scan_ctrl_steer_lut.sv
// Steering-vector ROM with one-cycle registered read.
// Entry layout: {Q4,Q3,Q2,Q1,I4,I3,I2,I1}.
module steer_lut
  import beam_scan_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int N_ANGLES    = DEF_N_ANGLES,
  parameter int ANGLE_W     = $clog2(N_ANGLES),
  parameter     LUT_FILE    = "steer.hex",
  parameter bit USE_FILE    = 1'b1
) (
  input  logic                     clk,
  input  logic [ANGLE_W-1:0]       i_addr,
  output logic [8*WORD_LENGTH-1:0] o_data
);

  localparam int DW = 8*WORD_LENGTH;

  logic [DW-1:0] r_data;

  function automatic logic [DW-1:0] gen_word(
    input logic [ANGLE_W-1:0] a
  );
    logic [DW-1:0] w;
    int p;
    w = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      p = steer_phase(int'(a), e);
      w[e*WORD_LENGTH +: WORD_LENGTH] =
        WORD_LENGTH'(cos16(p));
      w[(e+N_ELEM)*WORD_LENGTH +: WORD_LENGTH] =
        WORD_LENGTH'(sin16(p));
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    r_data <= gen_word(i_addr);
  end

  assign o_data = r_data;

endmodule

// File: rtl/beam_scan_ctrl.sv
// DoA peak search: latch a snapshot, sweep the steering ROM through
// the external power block and report the strongest look direction.
module beam_scan_ctrl
  import beam_scan_pkg::*;
#(
  parameter int WORD_LENGTH   = DEF_WORD_LENGTH,
  parameter int Y_WORD_LENGTH = WORD_LENGTH*2+3,
  parameter int PWR_W         = 2*Y_WORD_LENGTH,
  parameter int N_ANGLES      = DEF_N_ANGLES,
  parameter int ANGLE_W       = $clog2(N_ANGLES),
  parameter     LUT_FILE      = "steer.hex",
  parameter bit USE_FILE      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_ELEM*WORD_LENGTH-1:0] in_I,
  input  logic [N_ELEM*WORD_LENGTH-1:0] in_Q,
  output logic [N_ELEM*WORD_LENGTH-1:0] samp_I_o,
  output logic [N_ELEM*WORD_LENGTH-1:0] samp_Q_o,
  output logic [N_ELEM*WORD_LENGTH-1:0] sv_I_o,
  output logic [N_ELEM*WORD_LENGTH-1:0] sv_Q_o,
  input  logic [PWR_W-1:0]            pwr_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ANGLE_W-1:0]          best_idx,
  output logic [PWR_W-1:0]            best_pwr
);

  localparam int VW = N_ELEM*WORD_LENGTH;
  localparam logic [ANGLE_W-1:0] LAST =
    ANGLE_W'(N_ANGLES-1);

  state_t r_state;
  state_t w_next;

  logic [VW-1:0]      r_samp_I;
  logic [VW-1:0]      r_samp_Q;
  logic [ANGLE_W-1:0] r_addr;
  logic               r_issue;
  logic [ANGLE_W-1:0] r_t_idx;
  logic               r_t_vld;
  logic               r_cap_last;
  logic [ANGLE_W-1:0] r_best_idx;
  logic [PWR_W-1:0]   r_best_pwr;

  logic          w_idle;
  logic          w_scan;
  logic          w_done;
  logic          w_accept;
  logic          w_take;
  logic [2*VW-1:0] w_lut;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)   w_next = SCAN;
      SCAN:    if (r_cap_last) w_next = DONE;
      DONE:    if (out_ready)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_idle = 1'b0;
    w_scan = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE:    w_idle = 1'b1;
      SCAN:    w_scan = 1'b1;
      DONE:    w_done = 1'b1;
      default: w_idle = 1'b0;
    endcase
  end

  assign in_ready = w_idle;
  assign out_valid = w_done;
  assign w_accept = w_idle & in_valid;

  // First capture of a scan loads unconditionally; strict compare
  // afterwards keeps the lowest index on ties.
  assign w_take = r_t_vld &&
    (r_t_idx == '0 || pwr_i > r_best_pwr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_I   <= '0;
      r_samp_Q   <= '0;
      r_addr     <= '0;
      r_issue    <= 1'b0;
      r_t_idx    <= '0;
      r_t_vld    <= 1'b0;
      r_cap_last <= 1'b0;
      r_best_idx <= '0;
      r_best_pwr <= '0;
    end else begin
      if (w_accept) begin
        r_samp_I <= in_I;
        r_samp_Q <= in_Q;
        r_addr   <= '0;
        r_issue  <= 1'b1;
      end else if (w_scan && r_issue) begin
        if (r_addr == LAST) r_issue <= 1'b0;
        else                r_addr  <= r_addr + 1'b1;
      end
      r_t_vld    <= w_scan && r_issue;
      r_t_idx    <= r_addr;
      r_cap_last <= r_t_vld && (r_t_idx == LAST);
      if (w_take) begin
        r_best_idx <= r_t_idx;
        r_best_pwr <= pwr_i;
      end
    end
  end

  steer_lut #(
    .WORD_LENGTH (WORD_LENGTH),
    .N_ANGLES    (N_ANGLES),
    .ANGLE_W     (ANGLE_W),
    .LUT_FILE    (LUT_FILE),
    .USE_FILE    (USE_FILE)
  ) u_lut (
    .clk    (clk),
    .i_addr (r_addr),
    .o_data (w_lut)
  );

  assign samp_I_o = r_samp_I;
  assign samp_Q_o = r_samp_Q;
  assign sv_I_o   = w_lut[VW-1:0];
  assign sv_Q_o   = w_lut[2*VW-1:VW];
  assign best_idx = r_best_idx;
  assign best_pwr = r_best_pwr;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Self-checking bench for beam_scan_ctrl; the bench plays the
// combinational power block and keeps its own peak-search model.
module tb_beam_scan_ctrl;

  localparam int W  = 12;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int PW = 54;
  localparam int VW = 4*W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_I = '0;
  logic [VW-1:0] in_Q = '0;
  logic [VW-1:0] samp_I_o, samp_Q_o;
  logic [VW-1:0] sv_I_o, sv_Q_o;
  logic [PW-1:0] pwr_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] best_idx;
  logic [PW-1:0] best_pwr;

  int n_checks = 0;
  int n_fail = 0;

  int snap_i[4];
  int snap_q[4];
  logic [VW-1:0] rec_i[N];
  logic [VW-1:0] rec_q[N];
  longint pw[N];
  longint fpw[N];
  bit use_force = 1'b0;
  logic [PW-1:0] garb;

  beam_scan_ctrl #(
    .WORD_LENGTH (W),
    .N_ANGLES    (N),
    .USE_FILE    (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .samp_I_o  (samp_I_o),
    .samp_Q_o  (samp_Q_o),
    .sv_I_o    (sv_I_o),
    .sv_Q_o    (sv_Q_o),
    .pwr_i     (pwr_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .best_idx  (best_idx),
    .best_pwr  (best_pwr)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack4(input int v[4]);
    logic [VW-1:0] r;
    r = '0;
    for (int e = 0; e < 4; e++) r[e*W +: W] = v[e][W-1:0];
    return r;
  endfunction

  // |sum(x*s)|^2 for the bench's own snapshot
  function automatic longint model_pwr(
    input logic [VW-1:0] vi, input logic [VW-1:0] vq
  );
    longint re, im;
    int c, d;
    re = 0;
    im = 0;
    for (int e = 0; e < 4; e++) begin
      c = int'($signed(vi[e*W +: W]));
      d = int'($signed(vq[e*W +: W]));
      re += longint'(snap_i[e])*c - longint'(snap_q[e])*d;
      im += longint'(snap_i[e])*d + longint'(snap_q[e])*c;
    end
    return re*re + im*im;
  endfunction

  task automatic rand_snap();
    for (int e = 0; e < 4; e++) begin
      snap_i[e] = int'($urandom_range(4094, 0)) - 2047;
      snap_q[e] = int'($urandom_range(4094, 0)) - 2047;
    end
  endtask

  task automatic accept_snap();
    in_I = pack4(snap_i);
    in_Q = pack4(snap_q);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (samp_I_o !== pack4(snap_i) ||
        samp_Q_o !== pack4(snap_q)) begin
      n_fail++;
      $display("FAIL samp_latch: got %h/%h want %h/%h",
        samp_I_o, samp_Q_o, pack4(snap_i), pack4(snap_q));
    end
  endtask

  // Runs from just after the acceptance edge to the DONE cycle.
  task automatic scan_body(input string nm);
    int ei;
    longint ep;
    pwr_i = garb;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s busy k=%0d: got %b want 00",
          nm, k, {in_ready, out_valid});
      end
      if (use_force) begin
        pw[k] = fpw[k];
      end else begin
        rec_i[k] = sv_I_o;
        rec_q[k] = sv_Q_o;
        pw[k] = model_pwr(sv_I_o, sv_Q_o);
      end
      pwr_i = PW'(pw[k]);
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s early_valid: got %b want 0", nm, out_valid);
    end
    pwr_i = garb;
    @(posedge clk); #1;
    ei = 0;
    ep = pw[0];
    for (int k = 1; k < N; k++) begin
      if (pw[k] > ep) begin
        ep = pw[k];
        ei = k;
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b want 1", nm, out_valid);
    end
    n_checks++;
    if (best_idx !== AW'(ei)) begin
      n_fail++;
      $display("FAIL %s best_idx: got %0d want %0d",
        nm, best_idx, ei);
    end
    n_checks++;
    if (best_pwr !== PW'(ep)) begin
      n_fail++;
      $display("FAIL %s best_pwr: got %0d want %0d",
        nm, best_pwr, ep);
    end
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s hs_idle: got %b want 10",
        nm, {in_ready, out_valid});
    end
  endtask

  task automatic check_reset_vals(input string nm);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s rdy_vld: got %b want 10",
        nm, {in_ready, out_valid});
    end
    n_checks++;
    if (best_idx !== '0 || best_pwr !== '0) begin
      n_fail++;
      $display("FAIL %s best: got %0d/%0d want 0/0",
        nm, best_idx, best_pwr);
    end
    n_checks++;
    if (samp_I_o !== '0 || samp_Q_o !== '0) begin
      n_fail++;
      $display("FAIL %s samp: got %h/%h want 0/0",
        nm, samp_I_o, samp_Q_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("reset");
  endtask

  task automatic test_random_scan();
    use_force = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rand_snap();
      accept_snap();
      scan_body("rand");
      handshake("rand");
    end
  endtask

  task automatic test_peak17();
    use_force = 1'b0;
    for (int e = 0; e < 4; e++) begin
      snap_i[e] = int'($signed(rec_i[17][e*W +: W]));
      snap_q[e] = -int'($signed(rec_q[17][e*W +: W]));
    end
    accept_snap();
    scan_body("peak17");
    n_checks++;
    if (best_idx !== AW'(17)) begin
      n_fail++;
      $display("FAIL peak17 idx: got %0d want 17", best_idx);
    end
    handshake("peak17");
  endtask

  task automatic forced_scan(input string nm, input int pk0,
                             input int pk1, input int want);
    use_force = 1'b1;
    for (int k = 0; k < N; k++)
      fpw[k] = longint'($urandom_range(999999, 0));
    fpw[pk0] = 2000000;
    fpw[pk1] = 2000000;
    rand_snap();
    accept_snap();
    scan_body(nm);
    n_checks++;
    if (best_idx !== AW'(want)) begin
      n_fail++;
      $display("FAIL %s want_idx: got %0d want %0d",
        nm, best_idx, want);
    end
    handshake(nm);
  endtask

  task automatic test_tie_and_edges();
    use_force = 1'b1;
    for (int k = 0; k < N; k++)
      fpw[k] = {$urandom(), $urandom()} & 64'h3F_FFFF_FFFF_FFFF;
    rand_snap();
    accept_snap();
    scan_body("bigrand");
    handshake("bigrand");
    forced_scan("tie", 5, 40, 5);
    forced_scan("edge0", 0, 0, 0);
    forced_scan("edge63", N-1, N-1, N-1);
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] old_i;
    logic [AW-1:0] hidx;
    logic [PW-1:0] hpwr;
    use_force = 1'b0;
    rand_snap();
    accept_snap();
    scan_body("hold");
    old_i = pack4(snap_i);
    hidx = best_idx;
    hpwr = best_pwr;
    rand_snap();
    in_I = pack4(snap_i);
    in_Q = pack4(snap_q);
    in_valid = 1'b1;
    pwr_i = garb;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b01 ||
          best_idx !== hidx || best_pwr !== hpwr ||
          samp_I_o !== old_i) begin
        n_fail++;
        $display("FAIL hold c=%0d: got %b %0d %0d %h want 01 %0d %0d %h",
          c, {in_ready, out_valid}, best_idx, best_pwr,
          samp_I_o, hidx, hpwr, old_i);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10 || samp_I_o !== old_i) begin
      n_fail++;
      $display("FAIL hs_no_relatch: got %b %h want 10 %h",
        {in_ready, out_valid}, samp_I_o, old_i);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || samp_I_o !== pack4(snap_i)) begin
      n_fail++;
      $display("FAIL b2b_accept: got %b %h want 0 %h",
        in_ready, samp_I_o, pack4(snap_i));
    end
    scan_body("b2b");
    handshake("b2b");
  endtask

  task automatic test_reset_mid();
    use_force = 1'b0;
    rand_snap();
    accept_snap();
    pwr_i = garb;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst_scan");
    rand_snap();
    accept_snap();
    scan_body("after_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst_done");
    forced_scan("post_rst", 33, 33, 33);
  endtask

  initial begin
    garb = '1;
    test_reset();
    test_random_scan();
    test_peak17();
    test_tie_and_edges();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
